// File: rtl/relu_pool_gen.sv
// relu_pool_gen: walks a convolution layer's output RAM window by window,
// takes the max of each POOL x POOL window, applies ReLU and streams one
// pooled value per window.
// Optional feature macro: RELU_POOL_SIGNED_EN (two's-complement data with a
// ReLU clamp); when undefined the data is unsigned and ReLU is identity.
module relu_pool_gen #(
    parameter int DATA_W   = 8,
    parameter int IN_W     = 24,
    parameter int IN_H     = 24,
    parameter int POOL     = 2,
    parameter int CHANNELS = 1,
    parameter int ADDR_W   = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      src_ready,
    input  logic                      src_write_complete,
    input  logic [DATA_W-1:0]         rd_data,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic [$clog2(CHANNELS):0] out_ch,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int CH_W  = $clog2(CHANNELS) + 1;
    localparam int CNT_W = 16;

    localparam logic [2:0]        P_LAST    = 3'(POOL - 1);
    localparam logic [CNT_W-1:0]  WC_LAST   = CNT_W'(IN_W / POOL - 1);
    localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(IN_H / POOL - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] POOL_STEP = ADDR_W'(POOL);
    localparam logic [ADDR_W-1:0] BLK_STEP  = ADDR_W'(POOL * IN_W);

    typedef enum logic [1:0] {IDLE, WAIT_SRC, RUN, DRAIN} state_t;

    state_t            state;
    logic [2:0]        ic;
    logic [2:0]        ir;
    logic [CNT_W-1:0]  wc;
    logic [CNT_W-1:0]  wr;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] row_start;
    logic [ADDR_W-1:0] win_base;
    logic [ADDR_W-1:0] blk_base;

    logic              first_elem;
    logic              last_elem;
    logic              last_addr;
    logic [ADDR_W-1:0] next_row;
    logic [ADDR_W-1:0] next_win;
    logic [ADDR_W-1:0] next_blk;

    logic              s1_valid, s1_first, s1_last, s1_final;
    logic [CH_W-1:0]   s1_ch;
    logic              s2_valid, s2_first, s2_last, s2_final;
    logic [CH_W-1:0]   s2_ch;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] larger;
    logic [DATA_W-1:0] pooled;

    assign rd_en      = (state == RUN) || ((state == WAIT_SRC) && src_ready);
    assign busy       = (state != IDLE);
    assign first_elem = (ic == 3'd0) && (ir == 3'd0);
    assign last_elem  = (ic == P_LAST) && (ir == P_LAST);
    assign last_addr  = last_elem && (wc == WC_LAST) && (wr == WR_LAST) && (ch == CH_LAST);
    assign next_row   = row_start + ROW_STEP;
    assign next_win   = win_base + POOL_STEP;
    assign next_blk   = blk_base + BLK_STEP;

    // Sequencer: state machine plus the address walk (column, in-window row,
    // window column, window row, channel), all built from adders only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ic        <= '0;
            ir        <= '0;
            wc        <= '0;
            wr        <= '0;
            ch        <= '0;
            row_start <= '0;
            win_base  <= '0;
            blk_base  <= '0;
            rd_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT_SRC;
                        ic        <= '0;
                        ir        <= '0;
                        wc        <= '0;
                        wr        <= '0;
                        ch        <= '0;
                        row_start <= '0;
                        win_base  <= '0;
                        blk_base  <= '0;
                        rd_addr   <= '0;
                    end
                end
                WAIT_SRC: begin
                    if (rd_en && last_addr) begin
                        state <= DRAIN;
                    end else if (src_write_complete) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (last_addr) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (rd_en && !last_addr) begin
                if (ic != P_LAST) begin
                    ic      <= ic + 3'd1;
                    rd_addr <= rd_addr + ADDR_W'(1);
                end else if (ir != P_LAST) begin
                    ic        <= '0;
                    ir        <= ir + 3'd1;
                    row_start <= next_row;
                    rd_addr   <= next_row;
                end else begin
                    ic <= '0;
                    ir <= '0;
                    if (wc != WC_LAST) begin
                        wc        <= wc + CNT_W'(1);
                        win_base  <= next_win;
                        row_start <= next_win;
                        rd_addr   <= next_win;
                    end else begin
                        wc        <= '0;
                        blk_base  <= next_blk;
                        win_base  <= next_blk;
                        row_start <= next_blk;
                        rd_addr   <= next_blk;
                        if (wr != WR_LAST) begin
                            wr <= wr + CNT_W'(1);
                        end else begin
                            wr <= '0;
                            ch <= ch + CH_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Running maximum of the current window and the ReLU applied to it.
    always_comb begin
        larger = acc;
`ifdef RELU_POOL_SIGNED_EN
        if ($signed(data_q) > $signed(acc)) begin
            larger = data_q;
        end
        pooled = larger[DATA_W-1] ? '0 : larger;
`else
        if (data_q > acc) begin
            larger = data_q;
        end
        pooled = larger;
`endif
    end

    // Datapath: tag each read, capture RAM data a cycle later, then fold it
    // into the accumulator and emit the pooled value on a window's last element.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_final  <= 1'b0;
            s1_ch     <= '0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_final  <= 1'b0;
            s2_ch     <= '0;
            data_q    <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            s1_valid <= rd_en;
            s1_first <= first_elem;
            s1_last  <= last_elem;
            s1_final <= last_addr;
            s1_ch    <= ch;

            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_final <= s1_final;
            s2_ch    <= s1_ch;
            if (s1_valid) begin
                data_q <= rd_data;
            end

            if (s2_valid) begin
                acc <= s2_first ? data_q : larger;
            end
            out_valid <= s2_valid && s2_last;
            out_last  <= s2_valid && s2_last && s2_final;
            done      <= s2_valid && s2_last && s2_final;
            if (s2_valid && s2_last) begin
                out_data <= pooled;
                out_ch   <= s2_ch;
            end
        end
    end

endmodule

// File: doc/relu_pool_gen.md
# relu_pool_gen

Parametrised ReLU + max-pool reader for the convolution feature-map RAMs. Runs after a convolution layer: walks the layer's output RAM window by window, takes the maximum of each POOL×POOL window, clamps it through ReLU, and streams one pooled value per window to the next layer. Generalises the per-layer fixed 24×24 / 2×2 / 8-bit readers to any map size, pool size, data width and channel count.

## Interface
- DATA_W, 8, element width
- IN_W, 24, input map width (multiple of POOL)
- IN_H, 24, input map height (multiple of POOL)
- POOL, 2, window side and stride, 2..4
- CHANNELS, 1, feature maps stored back to back in RAM
- ADDR_W, 11, RAM address width, ≥ clog2(CHANNELS·IN_W·IN_H)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a layer pass (sampled in IDLE only)
- src_ready  in  1  producer has written data far enough for one more read
- src_write_complete  in  1  producer finished the whole layer
- rd_data  in  DATA_W  RAM read data, 1-cycle latency
- rd_en  out  1  RAM read enable
- rd_addr  out  ADDR_W  RAM read address
- out_data  out  DATA_W  pooled, ReLU'd value
- out_valid  out  1  one-cycle strobe per window
- out_ch  out  clog2(CHANNELS)+1  channel of out_data
- out_last  out  1  with out_valid on final window of final channel
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, pass finished

## Operation
- States: IDLE → WAIT_SRC on start; WAIT_SRC → RUN on src_write_complete; RUN → DRAIN after last address issued; DRAIN → IDLE when final out_valid issued (done pulses that cycle). If src_write_complete arrives in WAIT_SRC together with the last address, go straight to DRAIN.
- Advance: in WAIT_SRC one read per cycle with src_ready=1 (rd_en=src_ready); in RUN one read every cycle; IDLE/DRAIN rd_en=0.
- Address of (ch,r,c) = ch·IN_W·IN_H + r·IN_W + c, computed with counters (no multiplier in the loop). Order: channel outermost, then window row, window column, then in-window row-major.
- Accumulator: on the cycle following an rd_en=1 cycle, rd_data is captured. First element of a window loads acc, subsequent ones acc = max(acc, rd_data). Last element: out_data ← ReLU(max(acc, rd_data)), out_valid next cycle.
- Counters wrap: in-window index at POOL²−1, window column at IN_W/POOL−1, window row at IN_H/POOL−1, channel at CHANNELS−1 (terminal).
- start while busy: ignored. src_ready/src_write_complete in IDLE: ignored.
- rst (any state, mid-pass included): state IDLE, all counters/acc 0, every output 0 next edge; no done, no partial out_valid.

## Timing
- Reset values: rd_en 0, rd_addr 0, out_data 0, out_valid 0, out_ch 0, out_last 0, busy 0, done 0.
- start at edge t → busy=1 at t+1; first rd_en no earlier than t+1.
- Address of last window element on edge t → rd_data sampled t+1 → out_valid/out_data at t+2.
- Unstalled RUN: one out_valid every POOL² cycles.
- done coincides with final out_valid (out_last=1); busy drops next cycle.
- Full pass, unstalled from start: CHANNELS·IN_W·IN_H + 3 cycles start-to-done.

## Configuration
- RELU_POOL_SIGNED_EN defined: rd_data treated two's complement; max is signed; result < 0 is output as 0 (ReLU).
- Not defined: unsigned compare; no clamp (ReLU identity, as for already non-negative maps). Addressing and timing identical.

## Test plan
- 4×4, POOL=2, 1 ch, RAM = 0..15, src_write_complete at start+1 → out_data 5,7,13,15; done with 4th valid; 19 cycles start-to-done.
- Same map, src_write_complete held off, src_ready toggling 1,0,1,0 → same 4 outputs, no address repeated or skipped, rd_en mirrors src_ready.
- RELU_POOL_SIGNED_EN, 4×4 window {−3,−1,−8,−2} and {−5,4,−1,0} → out_data 0 then 4; without macro (0xFD,0xFF,0xF8,0xFE) → 0xFF.
- CHANNELS=2, 4×4, POOL=2 → 8 outputs, out_ch 0×4 then 1×4, channel-1 first address 16, out_last only on 8th.
- POOL=3, 6×6 random map → 4 outputs matching model max per 3×3 window.
- rst asserted mid-RUN after 2 outputs → all outputs 0 next cycle, no done; new start reruns full pass from address 0 with correct results; start pulsed while busy has no effect.
